// File: rtl/morse_decoder_pkg.sv
// Shared char codes, pattern widths and FSM encoding for the Morse decoder.
// MORSE_WORD_GAP_EN adds the WORD state used for word-space emission.
package morse_decoder_pkg;

    localparam int CHAR_W = 5;
    localparam int SYM_W  = 5;
    localparam int LEN_W  = 3;

    localparam logic [CHAR_W-1:0] CHAR_CODE_0     = 5'd0;
    localparam logic [CHAR_W-1:0] CHAR_CODE_1     = 5'd1;
    localparam logic [CHAR_W-1:0] CHAR_CODE_2     = 5'd2;
    localparam logic [CHAR_W-1:0] CHAR_CODE_3     = 5'd3;
    localparam logic [CHAR_W-1:0] CHAR_CODE_4     = 5'd4;
    localparam logic [CHAR_W-1:0] CHAR_CODE_5     = 5'd5;
    localparam logic [CHAR_W-1:0] CHAR_CODE_6     = 5'd6;
    localparam logic [CHAR_W-1:0] CHAR_CODE_7     = 5'd7;
    localparam logic [CHAR_W-1:0] CHAR_CODE_8     = 5'd8;
    localparam logic [CHAR_W-1:0] CHAR_CODE_9     = 5'd9;
    localparam logic [CHAR_W-1:0] CHAR_CODE_A     = 5'd10;
    localparam logic [CHAR_W-1:0] CHAR_CODE_B     = 5'd11;
    localparam logic [CHAR_W-1:0] CHAR_CODE_C     = 5'd12;
    localparam logic [CHAR_W-1:0] CHAR_CODE_D     = 5'd13;
    localparam logic [CHAR_W-1:0] CHAR_CODE_E     = 5'd14;
    localparam logic [CHAR_W-1:0] CHAR_CODE_F     = 5'd15;
    localparam logic [CHAR_W-1:0] CHAR_CODE_BLANK = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
`ifdef MORSE_WORD_GAP_EN
        ST_SPACE = 2'd2,
        ST_WORD  = 2'd3
`else
        ST_SPACE = 2'd2
`endif
    } state_t;

    function automatic logic [LEN_W+SYM_W-1:0] pat(
        input int              len,
        input logic [SYM_W-1:0] bits
    );
        return {LEN_W'(len), bits};
    endfunction

endpackage

// File: rtl/morse_lut.sv
// Maps a dot/dash pattern (first symbol at bit len-1, 1 = dash) to a char code.
// Build option MORSE_WORD_GAP_EN does not affect this block.
module morse_lut
    import morse_decoder_pkg::*;
(
    input  logic [LEN_W-1:0]  sym_len,
    input  logic [SYM_W-1:0]  sym_bits,
    output logic [CHAR_W-1:0] code,
    output logic              valid
);

    always_comb begin
        code  = CHAR_CODE_BLANK;
        valid = 1'b1;
        unique case ({sym_len, sym_bits})
            pat(5, 5'b11111): code = CHAR_CODE_0;
            pat(5, 5'b01111): code = CHAR_CODE_1;
            pat(5, 5'b00111): code = CHAR_CODE_2;
            pat(5, 5'b00011): code = CHAR_CODE_3;
            pat(5, 5'b00001): code = CHAR_CODE_4;
            pat(5, 5'b00000): code = CHAR_CODE_5;
            pat(5, 5'b10000): code = CHAR_CODE_6;
            pat(5, 5'b11000): code = CHAR_CODE_7;
            pat(5, 5'b11100): code = CHAR_CODE_8;
            pat(5, 5'b11110): code = CHAR_CODE_9;
            pat(2, 5'b00001): code = CHAR_CODE_A;
            pat(4, 5'b01000): code = CHAR_CODE_B;
            pat(4, 5'b01010): code = CHAR_CODE_C;
            pat(3, 5'b00100): code = CHAR_CODE_D;
            pat(1, 5'b00000): code = CHAR_CODE_E;
            pat(4, 5'b00010): code = CHAR_CODE_F;
            default:          valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse key timing FSM: builds dot/dash patterns and emits one char per letter gap.
// Define MORSE_WORD_GAP_EN to also emit a blank after a word-length gap.
module morse_decoder
    import morse_decoder_pkg::*;
#(
    parameter int DOT_MAX_UNITS    = 2,
    parameter int LETTER_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS   = 7,
    parameter int CNT_W            = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              unit_tick,
    input  logic              key,
    output logic [CHAR_W-1:0] char,
    output logic              char_valid,
    output logic              err,
    output logic              busy
);

    if (LETTER_GAP_UNITS < 1 || WORD_GAP_UNITS <= LETTER_GAP_UNITS) begin : g_cfg_bad
        $error("morse_decoder: gap thresholds out of order");
    end

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DOT_MAX  = CNT_W'(DOT_MAX_UNITS);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(LETTER_GAP_UNITS - 1);
`ifdef MORSE_WORD_GAP_EN
    localparam logic [CNT_W-1:0] WRD_LAST = CNT_W'(WORD_GAP_UNITS - 1);
`endif

    state_t             state, state_nx;
    logic               key_q;
    logic               rise, fall;
    logic [CNT_W-1:0]   cnt;
    logic [SYM_W-1:0]   sym_bits;
    logic [LEN_W-1:0]   sym_len;
    logic               ovf;
    logic               push;
    logic               emit_letter;
    logic               emit_space;
    logic [CHAR_W-1:0]  lut_code;
    logic               lut_valid;
    logic               bad;

    assign rise = key & ~key_q;
    assign fall = ~key & key_q;
    assign bad  = ovf | ~lut_valid;
    assign busy = (state == ST_MARK) || (state == ST_SPACE);

    morse_lut u_lut (
        .sym_len  (sym_len),
        .sym_bits (sym_bits),
        .code     (lut_code),
        .valid    (lut_valid)
    );

    always_comb begin
        state_nx    = state;
        push        = 1'b0;
        emit_letter = 1'b0;
        emit_space  = 1'b0;
        unique case (state)
            ST_IDLE: if (rise) state_nx = ST_MARK;
            ST_MARK: begin
                if (fall) begin
                    push     = 1'b1;
                    state_nx = ST_SPACE;
                end
            end
            ST_SPACE: begin
                // The gap-ending tick wins over a coincident press.
                if (unit_tick && cnt == GAP_LAST) begin
                    emit_letter = 1'b1;
`ifdef MORSE_WORD_GAP_EN
                    state_nx = rise ? ST_MARK : ST_WORD;
`else
                    state_nx = rise ? ST_MARK : ST_IDLE;
`endif
                end else if (rise) begin
                    state_nx = ST_MARK;
                end
            end
`ifdef MORSE_WORD_GAP_EN
            ST_WORD: begin
                if (unit_tick && cnt == WRD_LAST) begin
                    emit_space = 1'b1;
                    state_nx   = rise ? ST_MARK : ST_IDLE;
                end else if (rise) begin
                    state_nx = ST_MARK;
                end
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q      <= 1'b0;
            cnt        <= '0;
            sym_bits   <= '0;
            sym_len    <= '0;
            ovf        <= 1'b0;
            char       <= CHAR_CODE_BLANK;
            char_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            key_q <= key;
            if (rise || fall)
                cnt <= '0;
            else if (unit_tick && state != ST_IDLE && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            if (emit_letter) begin
                sym_bits <= '0;
                sym_len  <= '0;
                ovf      <= 1'b0;
            end else if (push) begin
                if (sym_len == LEN_W'(SYM_W)) begin
                    ovf <= 1'b1;
                end else begin
                    sym_bits <= {sym_bits[SYM_W-2:0], (cnt > DOT_MAX)};
                    sym_len  <= sym_len + 1'b1;
                end
            end

            char_valid <= emit_letter | emit_space;
            err        <= emit_letter & bad;
            if (emit_letter)
                char <= bad ? CHAR_CODE_BLANK : lut_code;
            else if (emit_space)
                char <= CHAR_CODE_BLANK;
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder; word-gap checks follow MORSE_WORD_GAP_EN.
// Inputs change 1 time unit after posedge; outputs are checked there too.
`timescale 1ns/1ps
module tb_morse_decoder;
    import morse_decoder_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              unit_tick;
    logic              key;
    logic [CHAR_W-1:0] char;
    logic              char_valid;
    logic              err;
    logic              busy;

    int n_tests  = 0;
    int n_fail   = 0;
    int nv       = 0;
    int exp_nv   = 0;
    int lone_err = 0;

    morse_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .unit_tick  (unit_tick),
        .key        (key),
        .char       (char),
        .char_valid (char_valid),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (char_valid) nv++;
        if (err && !char_valid) lone_err++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic k, input logic t);
        key       = k;
        unit_tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) cyc(1'b0, 1'b1);
    endtask

    task automatic press(input int n);
        cyc(1'b1, 1'b0);
        repeat (n) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
    endtask

    task automatic letter(input logic [5:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            if (i != len - 1) gap(1);
            press(bits[i] ? 4 : 1);
        end
    endtask

    task automatic end_letter(input string tag, input logic [CHAR_W-1:0] ec, input logic ee);
        gap(2);
        chk({tag, "_early"}, char_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b1);
        cyc(1'b0, 1'b1);
        chk({tag, "_valid"}, char_valid, 1'b1);
        chk({tag, "_char"}, char, ec);
        chk({tag, "_err"}, err, ee);
        chk({tag, "_idle"}, busy, 1'b0);
        exp_nv++;
        cyc(1'b0, 1'b0);
        chk({tag, "_pulse"}, char_valid, 1'b0);
        chk({tag, "_hold"}, char, ec);
    endtask

    initial begin
        rst_n     = 1'b0;
        key       = 1'b0;
        unit_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_char", char, CHAR_CODE_BLANK);
        chk("rst_valid", char_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        gap(3);
        chk("idle_tick", nv, 0);

        letter(6'b0, 1);
        end_letter("e1", CHAR_CODE_E, 1'b0);

        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        end_letter("e0", CHAR_CODE_E, 1'b0);

        letter(6'b1000, 4);
        end_letter("b", CHAR_CODE_B, 1'b0);

        letter(6'b00111, 5);
        end_letter("two", CHAR_CODE_2, 1'b0);

        letter(6'b11111, 5);
        end_letter("zero", CHAR_CODE_0, 1'b0);

        letter(6'b11110, 5);
        end_letter("nine", CHAR_CODE_9, 1'b0);

        letter(6'b100, 3);
        end_letter("d", CHAR_CODE_D, 1'b0);

        letter(6'b0010, 4);
        end_letter("f", CHAR_CODE_F, 1'b0);

        letter(6'b10, 2);
        end_letter("n_unk", CHAR_CODE_BLANK, 1'b1);

        letter(6'b0, 1);
        end_letter("e_w", CHAR_CODE_E, 1'b0);
        gap(3);
        chk("word_early", char_valid, 1'b0);
        cyc(1'b0, 1'b1);
`ifdef MORSE_WORD_GAP_EN
        chk("word_valid", char_valid, 1'b1);
        chk("word_char", char, CHAR_CODE_BLANK);
        chk("word_err", err, 1'b0);
        exp_nv++;
`else
        chk("word_none", char_valid, 1'b0);
        chk("word_hold", char, CHAR_CODE_E);
`endif
        cyc(1'b0, 1'b0);

        letter(6'b000000, 6);
        end_letter("ovf", CHAR_CODE_BLANK, 1'b1);
        letter(6'b01111, 5);
        end_letter("one", CHAR_CODE_1, 1'b0);

        press(1);
        gap(2);
        cyc(1'b1, 1'b1);
        chk("rg_valid", char_valid, 1'b1);
        chk("rg_char", char, CHAR_CODE_E);
        chk("rg_err", err, 1'b0);
        chk("rg_busy", busy, 1'b1);
        exp_nv++;
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        gap(1);
        press(4);
        end_letter("rg_a", CHAR_CODE_A, 1'b0);

        letter(6'b01, 2);
        gap(1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", char_valid, 1'b0);
        chk("mr_char", char, CHAR_CODE_BLANK);
        chk("mr_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        gap(4);
        chk("mr_noemit", nv, exp_nv);
        chk("mr_char2", char, CHAR_CODE_BLANK);

        letter(6'b1010, 4);
        end_letter("c", CHAR_CODE_C, 1'b0);

        chk("n_emits", nv, exp_nv);
        chk("lone_err", lone_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
- Upstream neighbour of the char-to-7-segment converter.
- Turns a debounced Morse key level into char codes (`CHAR_W wide, the `CHAR_CODE_* set from defines.vh) and hands them to the display path.
- Times key-down and key-up periods in units of an external time-base strobe, builds the dot/dash pattern, and emits one char per letter gap.

Parameters:
- DOT_MAX_UNITS, 2: a press lasting <= this many unit ticks is a dot; a longer press is a dash.
- LETTER_GAP_UNITS, 3: key-up ticks that end a letter.
- WORD_GAP_UNITS, 7: key-up ticks that emit a space. Used only with the optional feature.
- CNT_W, 8: width of the saturating duration counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- unit_tick  in  1  one-cycle time-unit strobe.
- key  in  1  debounced, synchronised key level; 1 = pressed.
- char  out  `CHAR_W  last decoded char code; held until the next emit.
- char_valid  out  1  one-cycle pulse when char is updated.
- err  out  1  one-cycle pulse, together with char_valid, when the pattern is unknown or too long.
- busy  out  1  high while a letter is in progress (state MARK or SPACE).

Behaviour:
- Reset values: char = `CHAR_CODE_BLANK (added to defines.vh; displays as all segments off), char_valid = 0, err = 0, busy = 0. State is IDLE, counter = 0, sym_len = 0, sym_bits = 0, ovf = 0.
- key_q is registered each cycle. Rise = key & ~key_q; fall = ~key & key_q.
- Pattern store: sym_bits[4:0] and sym_len[2:0].
  - Each new symbol shifts in at the LSB (1 = dash, 0 = dot).
  - The first symbol ends up at bit sym_len-1.
  - A 6th symbol is not stored; it sets ovf.
- Counter increments on unit_tick and saturates at 2^CNT_W-1. It clears on every rise and every fall.
- FSM states and transitions:
  - IDLE: on rise, go to MARK.
  - MARK: count ticks. On fall, classify (count <= DOT_MAX_UNITS gives a dot, else a dash), store the symbol, go to SPACE. A zero-tick press is a dot.
  - SPACE: count ticks.
    - On rise, go to MARK; the letter continues and the gap is discarded.
    - When a unit_tick makes the count equal LETTER_GAP_UNITS, emit and go to IDLE.
  - Emit takes priority over a rise in the same cycle. The letter is emitted and the FSM goes to MARK with a fresh pattern; that press is the first symbol of the next letter.
- Emit:
  - char and char_valid are registered and appear the cycle after the threshold tick.
  - The pattern and ovf clear in the same cycle as the emit.
- Lookup table (dot = ., dash = -):
  - 0 -----, 1 .----, 2 ..---, 3 ...--, 4 ....-
  - 5 ....., 6 -...., 7 --..., 8 ---.., 9 ----.
  - A .-, B -..., C -.-., D -.., E ., F ..-.
  - Any other pattern, or ovf set: char = `CHAR_CODE_BLANK and err pulses.
- Reset mid-letter discards the pattern; no emit occurs.
- unit_tick while in IDLE has no effect.

Optional Feature:
- Macro: MORSE_WORD_GAP_EN.
- Defined:
  - After a letter emit, the FSM enters state WORD instead of IDLE.
  - WORD counts on from LETTER_GAP_UNITS. When the count reaches WORD_GAP_UNITS, it emits char = `CHAR_CODE_BLANK with err = 0 (a word space), then goes to IDLE.
  - A rise in WORD goes to MARK with no space emitted.
- Undefined: the WORD state and the WORD_GAP_UNITS logic are absent.

Decomposition:
- defines.vh holds `CHAR_W, the `CHAR_CODE_* codes (plus the new `CHAR_CODE_BLANK), the state encodings, and the pattern width (5) and length width (3).
- One combinational sub-module, morse_lut: inputs sym_len and sym_bits; outputs char code and a valid flag.
- The FSM, counter and pattern store stay in morse_decoder.

Test Plan:
- Press 1 tick, release, 3 idle ticks -> char = `CHAR_CODE_E with char_valid for exactly 1 cycle, 1 cycle after the 3rd tick; err = 0.
- Press 4 ticks, then gap 1 / press 1 / gap 1 / press 1 / gap 1 / press 1, then 3 idle ticks -> `CHAR_CODE_B.
- Enter ..--- with 1-tick gaps, then 3 idle ticks -> `CHAR_CODE_2.
- Enter six dots, then 3 idle ticks -> char = `CHAR_CODE_BLANK, err and char_valid pulse together, the next letter decodes normally.
- Enter .- and release; assert rst_n = 0 after 1 gap tick -> no char_valid, char = `CHAR_CODE_BLANK, busy = 0.
- Two cases, each with a rise in the same cycle as the 3rd gap tick:
  - `define MORSE_WORD_GAP_EN, enter "E", then 7 idle ticks -> `CHAR_CODE_E, then `CHAR_CODE_BLANK at tick 7 with err = 0.
  - Rise with the 3rd gap tick -> E emitted and the new press is captured as the next letter's first symbol.
